// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory port, decode handshake and branch redirect.
// Perf counter outputs exist only when FETCH_PERF_EN is defined.
interface fetch_if #(
  parameter int N = 64
);
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic [31:0]   imem_rdata;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [N-1:0]  instr_pc;
  logic          instr_ready;
  logic          redirect_en;
  logic [N-1:0]  redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [15:0]   perf_flushes;
`endif

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
`ifdef FETCH_PERF_EN
    output perf_fetched, perf_flushes,
`endif
    input  imem_rdata, instr_ready, redirect_en, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
`ifdef FETCH_PERF_EN
    input  perf_fetched, perf_flushes,
`endif
    output imem_rdata, instr_ready, redirect_en, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC, single-outstanding imem requests, 2-entry output FIFO, redirect flush.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_flushes counters.
module fetch_stage #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  pc;
  logic          vld_p1;
  logic [N-1:0]  pc_p1;
  logic [31:0]   fifo_instr [2];
  logic [N-1:0]  fifo_pc    [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;
  logic [2:0]    occ;
  logic          issue, push, pop, head_valid;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // A word returning this cycle is shown directly at the head while the FIFO is empty;
  // if decode does not take it, it is pushed and the head value stays the same.
  assign head_valid      = !reset && ((count != 2'd0) || vld_p1);
  assign bus.instr_valid = head_valid;
  assign bus.instr       = !head_valid ? 32'h0 :
                           (count != 2'd0) ? fifo_instr[rd_ptr] : bus.imem_rdata;
  assign bus.instr_pc    = !head_valid ? '0 :
                           (count != 2'd0) ? fifo_pc[rd_ptr] : pc_p1;

  assign pop  = head_valid && bus.instr_ready;
  assign push = vld_p1 && !bus.redirect_en && !reset;
  assign occ  = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state: every redirect (re)starts a one-cycle REDIR window
  always_comb begin
    state_nxt = RUN;
    if (bus.redirect_en) state_nxt = REDIR;
  end

  // Outputs: in REDIR the FIFO is empty and nothing is in flight, so the target issues at once
  always_comb begin
    issue = 1'b0;
    case (state)
      RUN:     issue = (occ < 3'd2);
      REDIR:   issue = 1'b1;
      default: issue = 1'b0;
    endcase
    if (reset || bus.redirect_en) issue = 1'b0;
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;

  // Stage p0 -> p1: control (pc, in-flight flag, FIFO pointers/count)
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= {RESET_PC[N-1:2], 2'b00};
      vld_p1 <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (bus.redirect_en) begin
      pc     <= {bus.redirect_pc[N-1:2], 2'b00};
      vld_p1 <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (issue) pc <= pc + N'(4);
      vld_p1 <= issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Stage p1 -> FIFO: data path, no reset
  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= pc;
    if (push) begin
      fifo_instr[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]    <= pc_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !pop && (count == 2'd2)));
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  logic [31:0] perf_fetched_q;
  logic [15:0] perf_flushes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (pop)             perf_fetched_q <= sat_inc32(perf_fetched_q);
      if (bus.redirect_en) perf_flushes_q <= sat_inc16(perf_flushes_q);
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/backpressure, redirects, mid-stream reset.
// Memory model returns 32'hF8400000 + address one cycle after each request.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [31:0] mem_q;

  fetch_if #(.N(64)) bus ();

  fetch_stage #(.N(64), .RESET_PC(64'h0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (bus.imem_req) mem_q <= 32'hF8400000 + bus.imem_addr[31:0];
  end
  assign bus.imem_rdata = mem_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
    chk({tag, "_pc"},    bus.instr_pc, pc);
    chk({tag, "_instr"}, 64'(bus.instr), 64'(32'hF8400000 + pc[31:0]));
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
    chk({tag, "_req"}, 64'(bus.imem_req), 64'(req));
    if (req) chk({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  initial begin
    reset           = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;

    // Reset held
    repeat (3) nxt();
    smp();
    chk("rst_req",   64'(bus.imem_req), 64'd0);
    chk("rst_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instr", 64'(bus.instr), 64'd0);
    chk("rst_pc",    bus.instr_pc, 64'd0);

    // Cycle 1..4: streaming at one instruction per cycle
    nxt(); reset = 1'b0; smp();
    chk_req("c1", 1'b1, 64'h0);
    chk("c1_valid", 64'(bus.instr_valid), 64'd0);
    nxt(); smp();
    chk_req("c2", 1'b1, 64'h4);
    chk_head("c2", 64'h0);
    nxt(); smp();
    chk_req("c3", 1'b1, 64'h8);
    chk_head("c3", 64'h4);
    nxt(); smp();
    chk_head("c4", 64'h8);

    // Cycle 5..9: decode stalls; two words buffer and requests stop
    nxt(); bus.instr_ready = 1'b0; smp();
    chk_head("c5", 64'hC);
    chk_req("c5", 1'b1, 64'h10);
    nxt(); smp();
    chk_req("c6", 1'b0, 64'h0);
    chk_head("c6", 64'hC);
    nxt(); smp();
    chk_req("c7", 1'b0, 64'h0);
    chk_head("c7", 64'hC);
    nxt(); smp();
    nxt(); smp();
    chk_req("c9", 1'b0, 64'h0);
    chk_head("c9", 64'hC);

    // Cycle 10..13: release, in-order delivery without gaps
    nxt(); bus.instr_ready = 1'b1; smp();
    chk_head("c10", 64'hC);
    chk_req("c10", 1'b1, 64'h14);
    nxt(); smp(); chk_head("c11", 64'h10);
    nxt(); smp(); chk_head("c12", 64'h14);
    nxt(); smp(); chk_head("c13", 64'h18);

    // Cycle 14..15: fill FIFO, then redirect to 0x100 while full
    nxt(); bus.instr_ready = 1'b0; smp();
    chk_head("c14", 64'h1C);
    nxt(); bus.redirect_en = 1'b1; bus.redirect_pc = 64'h100; smp();
    chk_req("c15", 1'b0, 64'h0);
    chk_head("c15", 64'h1C);
    nxt(); bus.redirect_en = 1'b0; bus.instr_ready = 1'b1; smp();
    chk("c16_valid", 64'(bus.instr_valid), 64'd0);
    chk_req("c16", 1'b1, 64'h100);
    nxt(); smp();
    chk_head("c17", 64'h100);
    chk_req("c17", 1'b1, 64'h104);
    nxt(); smp(); chk_head("c18", 64'h104);

    // Cycle 19..21: misaligned redirect target is forced to word alignment
    nxt(); bus.redirect_en = 1'b1; bus.redirect_pc = 64'h203; smp();
    chk_req("c19", 1'b0, 64'h0);
    chk_head("c19", 64'h108);
    nxt(); bus.redirect_en = 1'b0; smp();
    chk("c20_valid", 64'(bus.instr_valid), 64'd0);
    chk_req("c20", 1'b1, 64'h200);
    nxt(); smp(); chk_head("c21", 64'h200);

    // Cycle 22..26: back-to-back redirects, the later target wins
    nxt(); bus.redirect_en = 1'b1; bus.redirect_pc = 64'h40; smp();
    nxt(); bus.redirect_pc = 64'h80; smp();
    chk("c23_valid", 64'(bus.instr_valid), 64'd0);
    chk_req("c23", 1'b0, 64'h0);
    nxt(); bus.redirect_en = 1'b0; smp();
    chk("c24_valid", 64'(bus.instr_valid), 64'd0);
    chk_req("c24", 1'b1, 64'h80);
    nxt(); smp(); chk_head("c25", 64'h80);
    nxt(); smp(); chk_head("c26", 64'h84);
`ifdef FETCH_PERF_EN
    chk("c26_perf_flushes", 64'(bus.perf_flushes), 64'd4);
    chk("c26_perf_fetched", 64'(bus.perf_fetched), 64'd13);
`endif

    // Cycle 27..29: fill FIFO again (count=2)
    nxt(); bus.instr_ready = 1'b0; smp();
    chk_head("c27", 64'h88);
    nxt(); smp();
    chk_req("c28", 1'b0, 64'h0);
    nxt(); smp();
    chk_head("c29", 64'h88);

    // Cycle 30..33: reset mid-stream, then restart from RESET_PC
    nxt(); reset = 1'b1; smp();
    chk("c30_valid", 64'(bus.instr_valid), 64'd0);
    chk("c30_req",   64'(bus.imem_req), 64'd0);
    nxt(); smp();
    chk("c31_valid", 64'(bus.instr_valid), 64'd0);
    chk("c31_req",   64'(bus.imem_req), 64'd0);
    nxt(); reset = 1'b0; bus.instr_ready = 1'b1; smp();
    chk("c32_valid", 64'(bus.instr_valid), 64'd0);
    chk_req("c32", 1'b1, 64'h0);
`ifdef FETCH_PERF_EN
    chk("c32_perf_flushes", 64'(bus.perf_flushes), 64'd0);
    chk("c32_perf_fetched", 64'(bus.perf_fetched), 64'd0);
`endif
    nxt(); smp();
    chk_head("c33", 64'h0);
    chk_req("c33", 1'b1, 64'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
